mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- N-master to 1-slave arbiter for the native valid/ready memory bus used by the CPU core.
- Lets the RISC-V core, the matmul accelerator DMA and future masters share one memory/peripheral port.
- Selectable round-robin or fixed-priority arbitration, registered slave-side outputs, and a per-transaction timeout that completes hung accesses with an error word.

Parameters:
- NUM_MASTERS, 2, number of master ports (2..8).
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (index 0 highest).
- TIMEOUT_CYCLES, 1024, BUSY cycles before forced completion; 0 disables the timeout.
- ERR_RDATA, 32'hDEADBEEF, read data returned on timeout.
- ID_W, $clog2(NUM_MASTERS) (min 1), width of the grant index.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_valid  in  NUM_MASTERS  per-master request
- m_instr  in  NUM_MASTERS  per-master instruction-fetch flag
- m_addr  in  32*NUM_MASTERS  per-master address, master i at [32i+31:32i]
- m_wdata  in  32*NUM_MASTERS  per-master write data
- m_wstrb  in  4*NUM_MASTERS  per-master byte strobes (0 = read)
- m_ready  out  NUM_MASTERS  per-master completion pulse
- m_rdata  out  32*NUM_MASTERS  per-master read data
- s_valid  out  1  slave request (registered)
- s_instr  out  1  registered
- s_addr  out  32  registered
- s_wdata  out  32  registered
- s_wstrb  out  4  registered
- s_ready  in  1  slave completion
- s_rdata  in  32  slave read data
- grant_id  out  ID_W  index of current or most recent owner
- busy  out  1  transaction outstanding
- timeout_err  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset: state IDLE.
  - s_valid=0, s_instr=0, s_addr=0, s_wdata=0, s_wstrb=0.
  - m_ready=0, busy=0, timeout_err=0, grant_id=0.
  - Round-robin pointer last=NUM_MASTERS-1, so master 0 wins first.
  - Timeout counter=0.
  - Reset mid-transaction aborts silently: no m_ready pulse, s_valid drops next edge.
- States: IDLE, BUSY.
- IDLE, any m_valid high:
  - Select winner w. RR: first requester scanning last+1, last+2, ... modulo NUM_MASTERS. Fixed: lowest index.
  - At the clock edge: capture w's instr/addr/wdata/wstrb into s_* regs; s_valid=1, grant_id=w, busy=1, last=w (RR), counter=0; go BUSY.
  - Latency: m_valid seen at edge t gives s_valid high after edge t.
- BUSY, s_ready=1:
  - Combinationally in the same cycle: m_ready[grant_id]=1 and m_rdata[grant_id]=s_rdata.
  - Next edge: s_valid=0, busy=0, go IDLE.
  - A new grant is possible at the following edge, so there is 1 idle cycle minimum between transactions.
- BUSY, s_ready=0:
  - Counter increments each cycle.
  - If TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: same cycle m_ready[grant_id]=1, m_rdata[grant_id]=ERR_RDATA, timeout_err=1. Next edge: s_valid=0, go IDLE.
  - s_ready and timeout in the same cycle: s_ready wins, no error.
- Non-granted masters: m_ready=0, m_rdata=0 at all times.
- Masters must hold m_valid and payload until m_ready; the arbiter ignores payload changes after capture.
- If the owner's m_valid drops during BUSY, the transaction still completes and m_ready still pulses.
- m_ready is never asserted to more than one master per cycle.
- Counter width: $clog2(TIMEOUT_CYCLES+1), saturating.

Decomposition:
- Shared package mem_bus_pkg:
  - Bus field widths (ADDR_W=32, DATA_W=32, STRB_W=4).
  - State encoding (IDLE/BUSY).
  - Default ERR_RDATA constant.
- One natural sub-module, rr_priority_picker: combinational request vector plus last pointer in, one-hot grant and index out; mode parameter selects fixed priority.
- Top holds the FSM, capture registers and timeout counter.

Test Plan:
- Single read: NUM_MASTERS=2, master 1 reads 0x00800010, slave s_ready 3 cycles after s_valid with rdata 0x12345678 -> s_addr=0x00800010, s_wstrb=0; m_ready[1] pulses once with m_rdata 0x12345678; m_ready[0] stays 0.
- Round-robin fairness: both masters request continuously, slave ready after 1 cycle -> grant_id sequence 0,1,0,1 and each master completes 2 of 4 transactions.
- Fixed priority: PRIORITY_MODE=1, both request continuously -> master 0 wins every grant; master 1 is served only after master 0 drops m_valid.
- Write capture: master 0 writes 0xCAFEF00D with wstrb 4'b0011 to 0x00001000 and changes m_wdata after grant -> s_wdata stays 0xCAFEF00D, s_wstrb=4'b0011 until s_ready.
- Timeout: TIMEOUT_CYCLES=8, slave never ready -> exactly 8 BUSY cycles, then m_ready plus m_rdata=0xDEADBEEF plus timeout_err for 1 cycle; the next request is granted normally.
- Reset mid-op: assert reset during BUSY -> no m_ready pulse, all outputs at reset values after the edge, master 0 wins first after reset.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus field widths, arbiter state encoding and default error word
// for the native valid/ready memory bus.
package mem_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_arbiter_picker.sv
// Combinational request picker: round-robin starting after the last winner,
// or fixed priority (index 0 highest) when PRIORITY_MODE != 0.
module rr_priority_picker #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned ID_W          = 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [ID_W-1:0]        last_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [ID_W-1:0]        idx_o,
  output logic                   any_o
);

  always_comb begin
    int unsigned pos;
    logic [ID_W-1:0] pos_id;
    gnt_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    pos    = 0;
    pos_id = '0;
    // RR scans last+1 .. last+NUM_MASTERS, so the previous winner is checked last.
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      pos    = (PRIORITY_MODE != 0) ? k : (32'(last_i) + 1 + k) % NUM_MASTERS;
      pos_id = ID_W'(pos);
      if (!any_o && req_i[pos_id]) begin
        any_o = 1'b1;
        idx_o = pos_id;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master to 1-slave arbiter for the native memory bus with registered
// slave-side request and a per-transaction timeout returning an error word.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned       NUM_MASTERS    = 2,
  parameter int unsigned       PRIORITY_MODE  = 0,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
  parameter int unsigned       ID_W           = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_valid,
  input  logic [NUM_MASTERS-1:0]        m_instr,
  input  logic [ADDR_W*NUM_MASTERS-1:0] m_addr,
  input  logic [DATA_W*NUM_MASTERS-1:0] m_wdata,
  input  logic [STRB_W*NUM_MASTERS-1:0] m_wstrb,
  output logic [NUM_MASTERS-1:0]        m_ready,
  output logic [DATA_W*NUM_MASTERS-1:0] m_rdata,
  output logic                          s_valid,
  output logic                          s_instr,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  input  logic                          s_ready,
  input  logic [DATA_W-1:0]             s_rdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_MASTERS - 1);

  arb_state_e        state_q, state_d;
  logic              s_valid_q, s_valid_d;
  logic              s_instr_q, s_instr_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [STRB_W-1:0] s_wstrb_q, s_wstrb_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [ID_W-1:0]        pick_idx;
  logic                   pick_any;

  logic              instr_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;
  logic [STRB_W-1:0] wstrb_sel;

  logic complete;
  logic timeout_hit;
  logic done;

  rr_priority_picker #(
    .NUM_MASTERS  (NUM_MASTERS),
    .PRIORITY_MODE(PRIORITY_MODE),
    .ID_W         (ID_W)
  ) u_picker (
    .req_i (m_valid),
    .last_i(last_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    instr_sel = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    wstrb_sel = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (pick_gnt[i]) begin
        instr_sel = m_instr[i];
        addr_sel  = m_addr[i*ADDR_W +: ADDR_W];
        wdata_sel = m_wdata[i*DATA_W +: DATA_W];
        wstrb_sel = m_wstrb[i*STRB_W +: STRB_W];
      end
    end
  end

  // Slave completion takes precedence over a timeout landing in the same cycle.
  assign complete    = (state_q == BUSY) && s_ready;
  assign timeout_hit = (state_q == BUSY) && !s_ready && (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
  assign done        = complete || timeout_hit;

  always_comb begin
    state_d   = state_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_wstrb_d = s_wstrb_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = BUSY;
          s_valid_d = 1'b1;
          s_instr_d = instr_sel;
          s_addr_d  = addr_sel;
          s_wdata_d = wdata_sel;
          s_wstrb_d = wstrb_sel;
          grant_d   = pick_idx;
          last_d    = pick_idx;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        if (done) begin
          state_d   = IDLE;
          s_valid_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s_valid_q <= 1'b0;
      s_instr_q <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wstrb_q <= '0;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_wstrb_q <= s_wstrb_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    m_ready = '0;
    m_rdata = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (done && (grant_q == ID_W'(i))) begin
        m_ready[i]                 = 1'b1;
        m_rdata[i*DATA_W +: DATA_W] = complete ? s_rdata : ERR_RDATA;
      end
    end
  end

  assign s_valid     = s_valid_q;
  assign s_instr     = s_instr_q;
  assign s_addr      = s_addr_q;
  assign s_wdata     = s_wdata_q;
  assign s_wstrb     = s_wstrb_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q == BUSY);
  assign timeout_err = timeout_hit;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share stimulus;
// each scenario task checks the relevant instance against hand-derived values.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_valid;
  logic [1:0]  m_instr;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;

  logic [1:0]  a_m_ready, b_m_ready;
  logic [63:0] a_m_rdata, b_m_rdata;
  logic        a_s_valid, b_s_valid;
  logic        a_s_instr, b_s_instr;
  logic [31:0] a_s_addr, b_s_addr;
  logic [31:0] a_s_wdata, b_s_wdata;
  logic [3:0]  a_s_wstrb, b_s_wstrb;
  logic [0:0]  a_grant_id, b_grant_id;
  logic        a_busy, b_busy;
  logic        a_timeout_err, b_timeout_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .NUM_MASTERS   (2),
    .PRIORITY_MODE (0),
    .TIMEOUT_CYCLES(8)
  ) dut_rr (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(a_m_ready), .m_rdata(a_m_rdata),
    .s_valid(a_s_valid), .s_instr(a_s_instr), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant_id(a_grant_id), .busy(a_busy), .timeout_err(a_timeout_err)
  );

  mem_bus_arbiter #(
    .NUM_MASTERS   (2),
    .PRIORITY_MODE (1),
    .TIMEOUT_CYCLES(8)
  ) dut_fp (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(b_m_ready), .m_rdata(b_m_rdata),
    .s_valid(b_s_valid), .s_instr(b_s_instr), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .grant_id(b_grant_id), .busy(b_busy), .timeout_err(b_timeout_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; m_valid = '0; m_instr = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = 1'b0; s_rdata = '0;
    step(); step();
    vecs++; if ({a_s_valid, a_s_instr, a_s_addr, a_s_wdata, a_s_wstrb, a_m_ready, a_busy, a_timeout_err, a_grant_id} !== 75'd0) begin
      errs++; $display("FAIL reset_outputs: got %h exp 0", {a_s_valid, a_s_instr, a_s_addr, a_s_wdata, a_s_wstrb, a_m_ready, a_busy, a_timeout_err, a_grant_id}); end
    vecs++; if ({b_s_valid, b_busy, b_m_ready, b_grant_id} !== 5'd0) begin
      errs++; $display("FAIL reset_fp_outputs: got %h exp 0", {b_s_valid, b_busy, b_m_ready, b_grant_id}); end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    m_valid = 2'b10; m_instr = 2'b00; m_addr = {32'h0080_0010, 32'h0}; m_wstrb = '0; s_ready = 1'b0;
    step();
    vecs++; if (a_s_valid !== 1'b1) begin errs++; $display("FAIL rd_s_valid: got %h exp 1", a_s_valid); end
    vecs++; if (a_s_addr !== 32'h0080_0010) begin errs++; $display("FAIL rd_s_addr: got %h exp 00800010", a_s_addr); end
    vecs++; if (a_s_wstrb !== 4'h0) begin errs++; $display("FAIL rd_s_wstrb: got %h exp 0", a_s_wstrb); end
    vecs++; if (a_grant_id !== 1'b1) begin errs++; $display("FAIL rd_grant: got %h exp 1", a_grant_id); end
    vecs++; if (a_busy !== 1'b1) begin errs++; $display("FAIL rd_busy: got %h exp 1", a_busy); end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) step();
      vecs++; if (a_m_ready !== 2'b00) begin errs++; $display("FAIL rd_wait_ready c%0d: got %b exp 00", c, a_m_ready); end
    end
    step();
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    vecs++; if (a_m_ready !== 2'b10) begin errs++; $display("FAIL rd_m_ready: got %b exp 10", a_m_ready); end
    vecs++; if (a_m_rdata !== {32'h1234_5678, 32'h0}) begin errs++; $display("FAIL rd_m_rdata: got %h exp 1234567800000000", a_m_rdata); end
    m_valid = 2'b00;
    step();
    s_ready = 1'b0;
    vecs++; if ({a_s_valid, a_busy, a_m_ready} !== 4'b0) begin errs++; $display("FAIL rd_after: got %b exp 0000", {a_s_valid, a_busy, a_m_ready}); end
  endtask

  task automatic test_round_robin();
    int c0, c1, exp_id;
    c0 = 0; c1 = 0;
    m_valid = 2'b11; m_addr = {32'h0000_0200, 32'h0000_0100}; m_wstrb = '0;
    s_ready = 1'b1; s_rdata = 32'hA5A5_0000;
    for (int t = 0; t < 4; t++) begin
      exp_id = t % 2;
      step();
      vecs++; if (a_grant_id !== 1'(exp_id)) begin errs++; $display("FAIL rr_grant t%0d: got %h exp %0d", t, a_grant_id, exp_id); end
      vecs++; if (a_s_addr !== ((exp_id == 1) ? 32'h200 : 32'h100)) begin errs++; $display("FAIL rr_addr t%0d: got %h", t, a_s_addr); end
      vecs++; if (a_m_ready !== ((exp_id == 1) ? 2'b10 : 2'b01)) begin errs++; $display("FAIL rr_ready t%0d: got %b", t, a_m_ready); end
      c0 += int'(a_m_ready[0]);
      c1 += int'(a_m_ready[1]);
      step();
      vecs++; if (a_busy !== 1'b0) begin errs++; $display("FAIL rr_idle_gap t%0d: got %h exp 0", t, a_busy); end
    end
    m_valid = 2'b00;
    vecs++; if (c0 != 2 || c1 != 2) begin errs++; $display("FAIL rr_counts: got %0d/%0d exp 2/2", c0, c1); end
  endtask

  task automatic test_fixed_priority();
    m_valid = 2'b11; m_addr = {32'h0000_0200, 32'h0000_0100}; s_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      step();
      vecs++; if (b_grant_id !== 1'b0) begin errs++; $display("FAIL fp_grant t%0d: got %h exp 0", t, b_grant_id); end
      vecs++; if (b_m_ready !== 2'b01) begin errs++; $display("FAIL fp_ready t%0d: got %b exp 01", t, b_m_ready); end
      step();
    end
    m_valid = 2'b10;
    step();
    vecs++; if (b_grant_id !== 1'b1) begin errs++; $display("FAIL fp_grant_m1: got %h exp 1", b_grant_id); end
    vecs++; if (b_m_ready !== 2'b10) begin errs++; $display("FAIL fp_ready_m1: got %b exp 10", b_m_ready); end
    vecs++; if (b_s_addr !== 32'h200) begin errs++; $display("FAIL fp_addr_m1: got %h exp 200", b_s_addr); end
    m_valid = 2'b00;
    step();
    s_ready = 1'b0;
  endtask

  task automatic test_write_capture();
    m_valid = 2'b01; m_addr[31:0] = 32'h0000_1000; m_wdata[31:0] = 32'hCAFE_F00D; m_wstrb[3:0] = 4'b0011;
    s_ready = 1'b0;
    step();
    vecs++; if ({a_s_addr, a_s_wdata, a_s_wstrb} !== {32'h1000, 32'hCAFE_F00D, 4'b0011}) begin
      errs++; $display("FAIL wr_capture: got %h %h %b", a_s_addr, a_s_wdata, a_s_wstrb); end
    m_wdata[31:0] = 32'h1111_1111; m_wstrb[3:0] = 4'b1111; m_addr[31:0] = 32'h0000_2000;
    for (int c = 0; c < 3; c++) begin
      step();
      vecs++; if ({a_s_addr, a_s_wdata, a_s_wstrb} !== {32'h1000, 32'hCAFE_F00D, 4'b0011}) begin
        errs++; $display("FAIL wr_hold c%0d: got %h %h %b", c, a_s_addr, a_s_wdata, a_s_wstrb); end
    end
    s_ready = 1'b1;
    #1;
    vecs++; if (a_m_ready !== 2'b01) begin errs++; $display("FAIL wr_ready: got %b exp 01", a_m_ready); end
    m_valid = 2'b00;
    step();
    s_ready = 1'b0;
    vecs++; if (a_busy !== 1'b0) begin errs++; $display("FAIL wr_done: got %h exp 0", a_busy); end
  endtask

  task automatic test_timeout();
    m_valid = 2'b10; m_addr[63:32] = 32'h0000_0300; s_ready = 1'b0; s_rdata = 32'h7777_7777;
    step();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) step();
      if (k < 8) begin
        vecs++; if ({a_busy, a_m_ready, a_timeout_err} !== 4'b1000) begin
          errs++; $display("FAIL to_wait k%0d: got %b exp 1000", k, {a_busy, a_m_ready, a_timeout_err}); end
      end else begin
        vecs++; if ({a_m_ready, a_timeout_err} !== 3'b101) begin
          errs++; $display("FAIL to_fire: got %b exp 101", {a_m_ready, a_timeout_err}); end
        vecs++; if (a_m_rdata !== {32'hDEAD_BEEF, 32'h0}) begin
          errs++; $display("FAIL to_rdata: got %h exp deadbeef00000000", a_m_rdata); end
      end
    end
    m_valid = 2'b00;
    step();
    vecs++; if ({a_busy, a_s_valid, a_timeout_err, a_m_ready} !== 5'b0) begin
      errs++; $display("FAIL to_after: got %b exp 00000", {a_busy, a_s_valid, a_timeout_err, a_m_ready}); end
    m_valid = 2'b01; m_addr[31:0] = 32'h0000_0400; s_rdata = 32'h600D_F00D;
    step();
    vecs++; if ({a_s_valid, a_grant_id} !== 2'b10) begin errs++; $display("FAIL to_next_grant: got %b exp 10", {a_s_valid, a_grant_id}); end
    s_ready = 1'b1;
    #1;
    vecs++; if ({a_m_ready, a_timeout_err} !== 3'b010) begin errs++; $display("FAIL to_next_ready: got %b exp 010", {a_m_ready, a_timeout_err}); end
    vecs++; if (a_m_rdata[31:0] !== 32'h600D_F00D) begin errs++; $display("FAIL to_next_rdata: got %h exp 600df00d", a_m_rdata[31:0]); end
    m_valid = 2'b00;
    step();
    s_ready = 1'b0;
  endtask

  task automatic test_ready_at_timeout();
    m_valid = 2'b01; s_ready = 1'b0;
    step();
    repeat (7) step();
    s_ready = 1'b1; s_rdata = 32'h5EAD_1E55;
    #1;
    vecs++; if ({a_m_ready, a_timeout_err} !== 3'b010) begin errs++; $display("FAIL race_ready: got %b exp 010", {a_m_ready, a_timeout_err}); end
    vecs++; if (a_m_rdata !== {32'h0, 32'h5EAD_1E55}) begin errs++; $display("FAIL race_rdata: got %h exp 000000005ead1e55", a_m_rdata); end
    m_valid = 2'b00;
    step();
    s_ready = 1'b0;
    vecs++; if (a_busy !== 1'b0) begin errs++; $display("FAIL race_done: got %h exp 0", a_busy); end
  endtask

  task automatic test_reset_mid_op();
    m_valid = 2'b10; m_addr = {32'h0000_0600, 32'h0000_0500}; s_ready = 1'b0;
    step();
    vecs++; if ({a_busy, a_grant_id} !== 2'b11) begin errs++; $display("FAIL rst_busy: got %b exp 11", {a_busy, a_grant_id}); end
    step();
    reset = 1'b1; m_valid = 2'b11;
    #1;
    vecs++; if (a_m_ready !== 2'b00) begin errs++; $display("FAIL rst_no_ready: got %b exp 00", a_m_ready); end
    step();
    vecs++; if ({a_s_valid, a_s_instr, a_s_addr, a_s_wdata, a_s_wstrb, a_m_ready, a_busy, a_timeout_err, a_grant_id} !== 75'd0) begin
      errs++; $display("FAIL rst_outputs: got %h exp 0", {a_s_valid, a_s_instr, a_s_addr, a_s_wdata, a_s_wstrb, a_m_ready, a_busy, a_timeout_err, a_grant_id}); end
    reset = 1'b0;
    step();
    vecs++; if ({a_s_valid, a_grant_id} !== 2'b10) begin errs++; $display("FAIL rst_first_grant: got %b exp 10", {a_s_valid, a_grant_id}); end
    vecs++; if (a_s_addr !== 32'h500) begin errs++; $display("FAIL rst_first_addr: got %h exp 500", a_s_addr); end
    s_ready = 1'b1;
    #1;
    vecs++; if (a_m_ready !== 2'b01) begin errs++; $display("FAIL rst_first_ready: got %b exp 01", a_m_ready); end
    m_valid = 2'b00;
    step();
    s_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_write_capture();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
